fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program-counter sequencer: IDLE/RUN/HALTED control with a small branch-target
// table and a saturating executed-cycle counter. All outputs are registered.
module fetch_unit #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PC_W-1:0]   StartAddr,
  input  logic              BranchEn,
  input  logic [LUT_AW-1:0] TargSel,
  input  logic              Halt,
  input  logic              Stall,
  input  logic              LutWrEn,
  input  logic [LUT_AW-1:0] LutWrAddr,
  input  logic [PC_W-1:0]   LutWrData,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              InstrValid,
  output logic              Done,
  output logic [15:0]       CycleCount
);

  localparam int LUT_N = 2**LUT_AW;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t                state;
  logic [PC_W-1:0]       lut [LUT_N];

  // Table write and branch read share one edge; the NBA gives the branch the old entry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (LutWrEn) begin
      lut[LutWrAddr] <= LutWrData;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      InstrValid <= 1'b0;
      Done       <= 1'b0;
      CycleCount <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (Start) begin
            state      <= RUN;
            ProgCtr    <= StartAddr;
            CycleCount <= '0;
            InstrValid <= 1'b1;
            Done       <= 1'b0;
          end
        end
        RUN: begin
          if (CycleCount != 16'hFFFF) CycleCount <= CycleCount + 16'd1;
          if (Halt) begin
            state      <= HALTED;
            InstrValid <= 1'b0;
            Done       <= 1'b1;
          end else if (Stall) begin
            ProgCtr <= ProgCtr;
          end else if (BranchEn) begin
            ProgCtr <= lut[TargSel];
          end else begin
            ProgCtr <= ProgCtr + PC_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          InstrValid <= 1'b0;
          Done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task drives one scenario and checks inline.
module tb_fetch_unit;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;

  logic              Clk = 1'b0;
  logic              Reset, Start, BranchEn, Halt, Stall, LutWrEn;
  logic [PC_W-1:0]   StartAddr, LutWrData;
  logic [LUT_AW-1:0] TargSel, LutWrAddr;
  logic [PC_W-1:0]   ProgCtr;
  logic              InstrValid, Done;
  logic [15:0]       CycleCount;

  int vecs = 0;
  int errs = 0;

  fetch_unit #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .BranchEn(BranchEn), .TargSel(TargSel), .Halt(Halt), .Stall(Stall),
    .LutWrEn(LutWrEn), .LutWrAddr(LutWrAddr), .LutWrData(LutWrData),
    .ProgCtr(ProgCtr), .InstrValid(InstrValid), .Done(Done), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Start = 0; StartAddr = '0; BranchEn = 0; TargSel = '0; Halt = 0; Stall = 0;
    LutWrEn = 0; LutWrAddr = '0; LutWrData = '0;
  endtask

  task automatic do_reset();
    Reset = 1; #2; Reset = 0; #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1; #3;
    vecs++; if (ProgCtr !== 10'h000) begin errs++; $display("FAIL reset_pc got %h exp 000", ProgCtr); end
    vecs++; if ({InstrValid, Done} !== 2'b00) begin errs++; $display("FAIL reset_flags got %b exp 00", {InstrValid, Done}); end
    vecs++; if (CycleCount !== 16'h0000) begin errs++; $display("FAIL reset_cc got %h exp 0000", CycleCount); end
    Reset = 0;
    step();
    // IDLE ignores Halt/Stall/BranchEn
    Halt = 1; Stall = 1; BranchEn = 1;
    step();
    vecs++; if ({InstrValid, Done, ProgCtr} !== {2'b00, 10'h000}) begin
      errs++; $display("FAIL idle_ignore got iv=%b d=%b pc=%h exp iv=0 d=0 pc=000", InstrValid, Done, ProgCtr); end
    idle_inputs();
  endtask

  task automatic test_sequential();
    logic [PC_W-1:0] exp_pc [4];
    exp_pc = '{10'h005, 10'h006, 10'h007, 10'h008};
    do_reset();
    Start = 1; StartAddr = 10'h005; Halt = 1;  // Halt ignored while IDLE
    step();
    Start = 0; Halt = 0;
    for (int i = 0; i < 4; i++) begin
      vecs++; if (ProgCtr !== exp_pc[i] || InstrValid !== 1'b1) begin
        errs++; $display("FAIL seq_pc[%0d] got pc=%h iv=%b exp pc=%h iv=1", i, ProgCtr, InstrValid, exp_pc[i]); end
      step();
    end
    vecs++; if (CycleCount !== 16'd4 || ProgCtr !== 10'h009) begin
      errs++; $display("FAIL seq_cc got cc=%0d pc=%h exp cc=4 pc=009", CycleCount, ProgCtr); end
    // Start in RUN is ignored
    Start = 1; StartAddr = 10'h300;
    step();
    Start = 0;
    vecs++; if (ProgCtr !== 10'h00A || CycleCount !== 16'd5) begin
      errs++; $display("FAIL run_start_ignored got pc=%h cc=%0d exp pc=00a cc=5", ProgCtr, CycleCount); end
  endtask

  task automatic test_branch();
    do_reset();
    LutWrEn = 1; LutWrAddr = 4'd3; LutWrData = 10'h120;
    step();
    LutWrEn = 0;
    Start = 1; StartAddr = 10'h010;
    step();
    Start = 0; BranchEn = 1; TargSel = 4'd3;
    step();
    vecs++; if (ProgCtr !== 10'h120) begin errs++; $display("FAIL branch_lut3 got %h exp 120", ProgCtr); end
    LutWrEn = 1; LutWrAddr = 4'd3; LutWrData = 10'h200;
    step();
    LutWrEn = 0;
    vecs++; if (ProgCtr !== 10'h120) begin errs++; $display("FAIL branch_same_cycle_write got %h exp 120", ProgCtr); end
    step();
    vecs++; if (ProgCtr !== 10'h200) begin errs++; $display("FAIL branch_new_value got %h exp 200", ProgCtr); end
    BranchEn = 0;
    step();
    vecs++; if (ProgCtr !== 10'h201) begin errs++; $display("FAIL branch_then_seq got %h exp 201", ProgCtr); end
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] exp_pc [3];
    exp_pc = '{10'h3FE, 10'h3FF, 10'h000};
    do_reset();
    Start = 1; StartAddr = 10'h3FE;
    step();
    Start = 0;
    for (int i = 0; i < 3; i++) begin
      vecs++; if (ProgCtr !== exp_pc[i]) begin
        errs++; $display("FAIL wrap_pc[%0d] got %h exp %h", i, ProgCtr, exp_pc[i]); end
      step();
    end
  endtask

  task automatic test_stall_halt();
    do_reset();
    LutWrEn = 1; LutWrAddr = 4'd3; LutWrData = 10'h155;
    step();
    LutWrEn = 0; Start = 1; StartAddr = 10'h010;
    step();
    Start = 0; Stall = 1; BranchEn = 1; TargSel = 4'd3;
    step();
    vecs++; if (ProgCtr !== 10'h010 || CycleCount !== 16'd1 || InstrValid !== 1'b1) begin
      errs++; $display("FAIL stall_over_branch got pc=%h cc=%0d iv=%b exp pc=010 cc=1 iv=1", ProgCtr, CycleCount, InstrValid); end
    BranchEn = 0; Halt = 1;
    step();
    Halt = 0; Stall = 0;
    vecs++; if ({Done, InstrValid} !== 2'b10 || ProgCtr !== 10'h010 || CycleCount !== 16'd2) begin
      errs++; $display("FAIL halt_over_stall got d=%b iv=%b pc=%h cc=%0d exp d=1 iv=0 pc=010 cc=2", Done, InstrValid, ProgCtr, CycleCount); end
    BranchEn = 1;
    step(); step();
    BranchEn = 0;
    vecs++; if (Done !== 1'b1 || ProgCtr !== 10'h010 || CycleCount !== 16'd2) begin
      errs++; $display("FAIL halted_hold got d=%b pc=%h cc=%0d exp d=1 pc=010 cc=2", Done, ProgCtr, CycleCount); end
    Start = 1; StartAddr = 10'h040;
    step();
    Start = 0;
    vecs++; if ({Done, InstrValid} !== 2'b01 || ProgCtr !== 10'h040 || CycleCount !== 16'd0) begin
      errs++; $display("FAIL restart got d=%b iv=%b pc=%h cc=%0d exp d=0 iv=1 pc=040 cc=0", Done, InstrValid, ProgCtr, CycleCount); end
    step();
    vecs++; if (ProgCtr !== 10'h041 || CycleCount !== 16'd1) begin
      errs++; $display("FAIL restart_run got pc=%h cc=%0d exp pc=041 cc=1", ProgCtr, CycleCount); end
  endtask

  task automatic test_async_reset();
    do_reset();
    LutWrEn = 1; LutWrAddr = 4'd3; LutWrData = 10'h2AA;
    step();
    LutWrEn = 0; Start = 1; StartAddr = 10'h077;
    step();
    Start = 0;
    step(); step();
    #2 Reset = 1;
    #1;
    vecs++; if ({ProgCtr, InstrValid, Done, CycleCount} !== '0) begin
      errs++; $display("FAIL async_reset got pc=%h iv=%b d=%b cc=%0d exp all zero", ProgCtr, InstrValid, Done, CycleCount); end
    Reset = 0;
    step(); step(); step();
    vecs++; if (ProgCtr !== 10'h000 || InstrValid !== 1'b0) begin
      errs++; $display("FAIL post_reset_idle got pc=%h iv=%b exp pc=000 iv=0", ProgCtr, InstrValid); end
    Start = 1; StartAddr = 10'h050;
    step();
    Start = 0; BranchEn = 1; TargSel = 4'd3;
    step();
    BranchEn = 0;
    vecs++; if (ProgCtr !== 10'h000) begin errs++; $display("FAIL lut_cleared got %h exp 000", ProgCtr); end
  endtask

  task automatic test_saturate();
    do_reset();
    Start = 1; StartAddr = 10'h123;
    step();
    Start = 0; Stall = 1;
    repeat (65535) step();
    vecs++; if (CycleCount !== 16'hFFFF || ProgCtr !== 10'h123) begin
      errs++; $display("FAIL cc_reach_max got cc=%h pc=%h exp cc=ffff pc=123", CycleCount, ProgCtr); end
    step(); step();
    vecs++; if (CycleCount !== 16'hFFFF) begin errs++; $display("FAIL cc_saturate got %h exp ffff", CycleCount); end
    Stall = 0;
  endtask

  initial begin
    idle_inputs();
    Reset = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_stall_halt();
    test_async_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
